// File: rtl/nrisc_pkg.sv
// Shared constants for the nRisc data-side responder: I/O page addresses,
// STATUS bit positions and register reset values.
package nrisc_pkg;

  localparam logic [7:0] ADDR_OUT    = 8'hF0;
  localparam logic [7:0] ADDR_STATUS = 8'hF1;
  localparam logic [7:0] ADDR_IN     = 8'hF2;
  localparam logic [7:0] ADDR_TIMER  = 8'hF3;
  localparam logic [7:0] ADDR_CMP    = 8'hF4;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_MATCH = 3;

  localparam logic [7:0] CMP_RESET = 8'hFF;

  function automatic logic [7:0] status_byte(input logic match, input logic ovf,
                                             input logic full, input logic empty);
    logic [7:0] s;
    s             = 8'h00;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    s[STAT_OVF]   = ovf;
    s[STAT_MATCH] = match;
    return s;
  endfunction

endpackage

// File: rtl/nrisc_fifo.sv
// Synchronous byte FIFO with show-ahead head; a push while full is accepted
// only when a pop frees the slot on the same edge.
module nrisc_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = empty ? '0 : r_mem[r_rd_ptr];

  // Storage is not reset; the empty flag masks stale contents on head.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/nrisc_data_responder.sv
// Data-port responder for the nRisc core: byte RAM plus an I/O page with an
// output stream FIFO, synchronized input port and a timer/compare flag.
module nrisc_data_responder
  import nrisc_pkg::*;
#(
  parameter int RAM_WORDS  = 224,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic [7:0] Endereco,
  input  logic [7:0] DadoEscrita,
  input  logic       EscMem,
  input  logic       LerMem,
  output logic [7:0] LeDado,
  input  logic [7:0] EntradaIO,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    r_ram [RAM_WORDS];
  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [7:0]    r_timer;
  logic [7:0]    r_cmp;
  logic          r_match;
  logic          r_ovf;

  logic          w_in_ram;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_status;
  logic          w_wr_timer;
  logic          w_wr_cmp;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_rdata;

  assign w_in_ram    = ({1'b0, Endereco} < 9'(RAM_WORDS));
  assign w_push      = EscMem && (Endereco == ADDR_OUT);
  assign w_wr_status = EscMem && (Endereco == ADDR_STATUS);
  assign w_wr_timer  = EscMem && (Endereco == ADDR_TIMER);
  assign w_wr_cmp    = EscMem && (Endereco == ADDR_CMP);
  assign tx_valid    = !w_empty;
  assign w_pop       = tx_valid && tx_ready;

  nrisc_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (DadoEscrita),
    .head  (tx_data),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge Clock) begin
    if (EscMem && w_in_ram) r_ram[Endereco] <= DadoEscrita;
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
      r_timer <= 8'h00;
      r_cmp   <= CMP_RESET;
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_sync1 <= EntradaIO;
      r_sync2 <= r_sync1;
      r_timer <= w_wr_timer ? DadoEscrita : r_timer + 8'd1;
      if (w_wr_cmp) r_cmp <= DadoEscrita;
      // A compare hit on this edge outranks a clearing STATUS write.
      if (r_timer == r_cmp)  r_match <= 1'b1;
      else if (w_wr_status)  r_match <= 1'b0;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr_status)           r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    if (LerMem) begin
      if (w_in_ram) begin
        w_rdata = r_ram[Endereco];
      end else begin
        case (Endereco)
          ADDR_OUT:    w_rdata = 8'(w_count);
          ADDR_STATUS: w_rdata = status_byte(r_match, r_ovf, w_full, w_empty);
          ADDR_IN:     w_rdata = r_sync2;
          ADDR_TIMER:  w_rdata = r_timer;
          ADDR_CMP:    w_rdata = r_cmp;
          default:     w_rdata = 8'h00;
        endcase
      end
    end
  end

  assign LeDado = w_rdata;

endmodule
